// File: rtl/ahb_master_bridge_pkg.sv
// Shared types and constants for the AHB-lite master bridge.
package ahb_master_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic [3:0] HPROT_FETCH = 4'b0010;
    localparam logic [3:0] HPROT_DATA  = 4'b0011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP,
        ST_ERR
    } state_t;

    // Which core port owns the current transfer.
    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

endpackage

// File: rtl/ahb_master_bridge_if.sv
// Core-side request/response ports and AHB-lite master signals in one bundle.
// 'master' is the bridge view, 'slave' is the surrounding core/slave view.
interface ahb_master_bridge_if;

    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;

    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [2:0]  dm_size;
    logic        dm_signed;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        dm_err;

    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [3:0]  hprot;
    logic        is_signed;
    logic [1:0]  htrans;
    logic        HSEL1;
    logic        HSEL2;
    logic [31:0] hwdata;

    logic [31:0] instruction;
    logic        hready_inst;
    logic        hresp_inst;
    logic [31:0] load_out;
    logic        hready_data;
    logic        hresp_data;

    modport master (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata, if_err,
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_size, dm_signed,
        output dm_gnt, dm_rvalid, dm_rdata, dm_err,
        output haddr, hwrite, hsize, hprot, is_signed, htrans, HSEL1, HSEL2, hwdata,
        input  instruction, hready_inst, hresp_inst, load_out, hready_data, hresp_data
    );

    modport slave (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        output dm_req, dm_we, dm_addr, dm_wdata, dm_size, dm_signed,
        input  dm_gnt, dm_rvalid, dm_rdata, dm_err,
        input  haddr, hwrite, hsize, hprot, is_signed, htrans, HSEL1, HSEL2, hwdata,
        output instruction, hready_inst, hresp_inst, load_out, hready_data, hresp_data
    );

endinterface

// File: rtl/ahb_master_bridge_addr_decode.sv
// Combinational region decode plus legality checks for one request.
// ROM wins if both regions would match.
module ahb_addr_decode
    import ahb_master_pkg::*;
#(
    parameter logic [31:0] ROM_BASE = 32'h0000_0000,
    parameter logic [31:0] ROM_MASK = 32'hFFFF_0000,
    parameter logic [31:0] RAM_BASE = 32'h1000_0000,
    parameter logic [31:0] RAM_MASK = 32'hFFFF_0000
) (
    input  logic [31:0] i_addr,
    input  logic [2:0]  i_size,
    input  logic        i_we,
    output logic        o_sel_rom,
    output logic        o_sel_ram,
    output logic        o_dec_err
);

    logic w_rom_hit, w_ram_hit, w_misalign;

    assign w_rom_hit  = (i_addr & ROM_MASK) == ROM_BASE;
    assign w_ram_hit  = (i_addr & RAM_MASK) == RAM_BASE;
    assign w_misalign = ((i_size == HSIZE_HALF) && i_addr[0]) ||
                        ((i_size == HSIZE_WORD) && (i_addr[1:0] != 2'b00));

    assign o_sel_rom = w_rom_hit;
    assign o_sel_ram = !w_rom_hit && w_ram_hit;
    assign o_dec_err = !(w_rom_hit || w_ram_hit) || (i_we && w_rom_hit) ||
                       (i_size > HSIZE_WORD) || w_misalign;

endmodule

// File: rtl/ahb_master_bridge.sv
// AHB-lite master: arbitrates fetch vs data port, decodes ROM/RAM, and runs
// one non-pipelined transfer at a time, returning data/error to the owner.
module ahb_master_bridge
    import ahb_master_pkg::*;
#(
    parameter logic [31:0] ROM_BASE = 32'h0000_0000,
    parameter logic [31:0] ROM_MASK = 32'hFFFF_0000,
    parameter logic [31:0] RAM_BASE = 32'h1000_0000,
    parameter logic [31:0] RAM_MASK = 32'hFFFF_0000
) (
    input  logic                clk,
    input  logic                reset,
    ahb_master_bridge_if.master bus
);

    state_t      r_state, w_state_nxt;
    owner_t      r_last_gnt, r_owner, w_req_owner;
    logic        w_take, w_pick_dm, w_if_gnt, w_dm_gnt;
    logic [31:0] w_req_addr;
    logic [2:0]  w_req_size;
    logic        w_req_we;
    logic        w_sel_rom, w_sel_ram, w_dec_err;
    logic        w_hready, w_hresp, w_in_bus, w_rsp, w_rsp_err;
    logic [31:0] w_bus_rdata;

    logic [31:0] r_haddr, r_wdata, r_if_rdata, r_dm_rdata;
    logic        r_hwrite, r_signed, r_sel_rom, r_sel_ram, r_resp;
    logic [2:0]  r_hsize;
    logic [3:0]  r_hprot;

    // Tie goes to whichever port was not granted last time.
    assign w_pick_dm   = bus.dm_req && (!bus.if_req || r_last_gnt == OWN_FETCH);
    assign w_take      = (r_state == ST_IDLE) && (bus.if_req || bus.dm_req);
    assign w_req_owner = w_pick_dm ? OWN_DATA : OWN_FETCH;
    assign w_req_addr  = w_pick_dm ? bus.dm_addr : bus.if_addr;
    assign w_req_size  = w_pick_dm ? bus.dm_size : HSIZE_WORD;
    assign w_req_we    = w_pick_dm && bus.dm_we;

    ahb_addr_decode #(
        .ROM_BASE (ROM_BASE),
        .ROM_MASK (ROM_MASK),
        .RAM_BASE (RAM_BASE),
        .RAM_MASK (RAM_MASK)
    ) u_dec (
        .i_addr    (w_req_addr),
        .i_size    (w_req_size),
        .i_we      (w_req_we),
        .o_sel_rom (w_sel_rom),
        .o_sel_ram (w_sel_ram),
        .o_dec_err (w_dec_err)
    );

    // Return path of whichever slave this transfer selected.
    assign w_hready    = r_sel_rom ? bus.hready_inst : bus.hready_data;
    assign w_hresp     = r_sel_rom ? bus.hresp_inst  : bus.hresp_data;
    assign w_bus_rdata = r_sel_rom ? bus.instruction : bus.load_out;

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state and combinational grants; grants only ever leave IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_if_gnt    = 1'b0;
        w_dm_gnt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_dm_gnt = w_pick_dm;
                w_if_gnt = bus.if_req && !w_pick_dm;
                if (w_take) w_state_nxt = w_dec_err ? ST_ERR : ST_ADDR;
            end
            ST_ADDR: if (w_hready) w_state_nxt = ST_DATA;
            ST_DATA: if (w_hready) w_state_nxt = ST_RESP;
            ST_RESP: w_state_nxt = ST_IDLE;
            ST_ERR:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Latch the granted request; capture the owner's read data at the end of
    // the data phase (or zero it on a decode error) so non-owner data holds.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_gnt <= OWN_FETCH;
            r_owner    <= OWN_FETCH;
            r_haddr    <= '0;
            r_hwrite   <= 1'b0;
            r_hsize    <= '0;
            r_hprot    <= '0;
            r_signed   <= 1'b0;
            r_wdata    <= '0;
            r_sel_rom  <= 1'b0;
            r_sel_ram  <= 1'b0;
            r_resp     <= 1'b0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            if (w_take) begin
                r_last_gnt <= w_req_owner;
                r_owner    <= w_req_owner;
                r_haddr    <= w_req_addr;
                r_hwrite   <= w_req_we;
                r_hsize    <= w_req_size;
                r_hprot    <= w_pick_dm ? HPROT_DATA : HPROT_FETCH;
                r_signed   <= w_pick_dm && bus.dm_signed;
                r_wdata    <= w_pick_dm ? bus.dm_wdata : '0;
                r_sel_rom  <= w_sel_rom;
                r_sel_ram  <= w_sel_ram;
                if (w_dec_err) begin
                    if (w_pick_dm) r_dm_rdata <= '0;
                    else           r_if_rdata <= '0;
                end
            end
            if (r_state == ST_DATA && w_hready) begin
                r_resp <= w_hresp;
                if (r_owner == OWN_DATA) r_dm_rdata <= w_bus_rdata;
                else                     r_if_rdata <= w_bus_rdata;
            end
        end
    end

    assign w_in_bus  = (r_state == ST_ADDR) || (r_state == ST_DATA);
    assign w_rsp     = (r_state == ST_RESP) || (r_state == ST_ERR);
    assign w_rsp_err = (r_state == ST_ERR) || r_resp;

    assign bus.if_gnt    = w_if_gnt;
    assign bus.dm_gnt    = w_dm_gnt;
    assign bus.if_rvalid = w_rsp && (r_owner == OWN_FETCH);
    assign bus.dm_rvalid = w_rsp && (r_owner == OWN_DATA);
    assign bus.if_err    = bus.if_rvalid && w_rsp_err;
    assign bus.dm_err    = bus.dm_rvalid && w_rsp_err;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.dm_rdata  = r_dm_rdata;

    assign bus.htrans    = (r_state == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign bus.HSEL1     = w_in_bus && r_sel_rom;
    assign bus.HSEL2     = w_in_bus && r_sel_ram;
    assign bus.haddr     = r_haddr;
    assign bus.hwrite    = r_hwrite;
    assign bus.hsize     = r_hsize;
    assign bus.hprot     = r_hprot;
    assign bus.is_signed = r_signed;
    assign bus.hwdata    = r_wdata;

endmodule

// File: tb/tb_ahb_master_bridge.sv
// Self-checking bench for ahb_master_bridge: scoreboard of expected
// responses pushed at grant time and popped when rvalid appears.
module tb_ahb_master_bridge;
    import ahb_master_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    ahb_master_bridge_if bus();

    ahb_master_bridge dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    // {if_rvalid, dm_rvalid, err, rdata}
    logic [34:0] sb[$];

    function automatic logic [34:0] obs();
        return {bus.if_rvalid, bus.dm_rvalid,
                bus.if_rvalid ? bus.if_err : bus.dm_err,
                bus.if_rvalid ? bus.if_rdata : bus.dm_rdata};
    endfunction

    task automatic next_cyc();
        @(posedge clk); #1;
    endtask

    task automatic wait_rsp(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(bus.if_rvalid || bus.dm_rvalid) && cyc < 20);
    endtask

    task automatic idle_inputs();
        bus.if_req = 0; bus.if_addr = '0;
        bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = '0; bus.dm_wdata = '0;
        bus.dm_size = HSIZE_WORD; bus.dm_signed = 0;
        bus.instruction = '0; bus.hready_inst = 1; bus.hresp_inst = 0;
        bus.load_out = '0; bus.hready_data = 1; bus.hresp_data = 0;
    endtask

    task automatic test_reset();
        logic [22:0] ctl;
        idle_inputs();
        reset = 0;
        @(negedge clk);
        ctl = {bus.htrans, bus.HSEL1, bus.HSEL2, bus.if_gnt, bus.dm_gnt, bus.if_rvalid,
               bus.dm_rvalid, bus.if_err, bus.dm_err, bus.hwrite, bus.is_signed, bus.hsize,
               bus.hprot, 6'd0};
        checks++;
        if (ctl !== '0) begin errors++; $display("FAIL reset_ctl got %h want 0", ctl); end
        checks++;
        if ({bus.haddr, bus.hwdata, bus.if_rdata, bus.dm_rdata} !== '0) begin
            errors++; $display("FAIL reset_data got %h %h %h %h want 0", bus.haddr, bus.hwdata, bus.if_rdata, bus.dm_rdata);
        end
        next_cyc();
        reset = 1;
        next_cyc();
    endtask

    task automatic test_arb();
        int g = 0, r = 0, cyc = 0, last = 0;
        logic [34:0] e;
        bus.if_addr = 32'h0000_0020; bus.dm_addr = 32'h1000_0008;
        bus.instruction = 32'h1111_0001; bus.load_out = 32'h2222_0002;
        bus.if_req = 1; bus.dm_req = 1;
        while ((g < 3 || r < 3) && cyc < 60) begin
            @(negedge clk); cyc++;
            if (bus.if_rvalid || bus.dm_rvalid) begin
                checks++;
                if (sb.size() == 0) begin errors++; $display("FAIL arb_rsp got %h want none", obs()); end
                else begin
                    e = sb.pop_front();
                    if (obs() !== e) begin errors++; $display("FAIL arb_rsp got %h want %h", obs(), e); end
                end
                r++;
            end
            if (bus.if_gnt || bus.dm_gnt) begin
                checks++;
                if (bus.if_gnt && bus.dm_gnt) begin errors++; $display("FAIL arb_excl got both want one"); end
                checks++;
                if (bus.dm_gnt !== (g != 1)) begin errors++; $display("FAIL arb_order grant %0d got dm=%b want %b", g, bus.dm_gnt, g != 1); end
                if (g > 0) begin
                    checks++;
                    if (cyc - last != 4) begin errors++; $display("FAIL arb_gap got %0d want 4", cyc - last); end
                end
                last = cyc;
                sb.push_back(bus.dm_gnt ? {2'b01, 1'b0, 32'h2222_0002} : {2'b10, 1'b0, 32'h1111_0001});
                g++;
                if (g == 3) begin
                    @(posedge clk); #1;
                    bus.if_req = 0; bus.dm_req = 0;
                end
            end
        end
        checks++;
        if (g != 3 || r != 3) begin errors++; $display("FAIL arb_timeout got %0d/%0d want 3/3", g, r); end
        next_cyc();
    endtask

    task automatic test_fetch();
        int cyc;
        logic [34:0] e;
        bus.instruction = 32'h0013_0093;
        bus.if_addr = 32'h0000_0010; bus.if_req = 1;
        @(negedge clk);
        checks++;
        if ({bus.if_gnt, bus.dm_gnt} !== 2'b10) begin errors++; $display("FAIL fetch_gnt got %b want 10", {bus.if_gnt, bus.dm_gnt}); end
        sb.push_back({2'b10, 1'b0, 32'h0013_0093});
        next_cyc();
        bus.if_req = 0;
        @(negedge clk);
        checks++;
        if ({bus.htrans, bus.HSEL1, bus.HSEL2, bus.hsize, bus.hprot, bus.haddr} !== {2'b10, 1'b1, 1'b0, 3'd2, 4'b0010, 32'h10}) begin
            errors++; $display("FAIL fetch_addr got %b %b%b %0d %b %h", bus.htrans, bus.HSEL1, bus.HSEL2, bus.hsize, bus.hprot, bus.haddr);
        end
        wait_rsp(cyc);
        checks++;
        if (cyc != 2) begin errors++; $display("FAIL fetch_lat got %0d want 2", cyc); end
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL fetch_rsp got %h want none", obs()); end
        else begin
            e = sb.pop_front();
            if (obs() !== e) begin errors++; $display("FAIL fetch_rsp got %h want %h", obs(), e); end
        end
        next_cyc();
    endtask

    task automatic test_store_stall();
        int cyc;
        logic [34:0] e;
        bus.load_out = '0;
        bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h1000_0004;
        bus.dm_wdata = 32'hDEAD_BEEF; bus.dm_size = HSIZE_WORD;
        @(negedge clk);
        checks++;
        if ({bus.if_gnt, bus.dm_gnt} !== 2'b01) begin errors++; $display("FAIL st_gnt got %b want 01", {bus.if_gnt, bus.dm_gnt}); end
        sb.push_back({2'b01, 1'b0, 32'h0});
        next_cyc();
        bus.dm_req = 0; bus.dm_we = 0;
        @(negedge clk);
        checks++;
        if ({bus.HSEL2, bus.HSEL1, bus.htrans, bus.hwrite, bus.hsize, bus.hprot, bus.haddr} !== {1'b1, 1'b0, 2'b10, 1'b1, 3'd2, 4'b0011, 32'h1000_0004}) begin
            errors++; $display("FAIL st_addr got %b%b %b %b %0d %b %h", bus.HSEL2, bus.HSEL1, bus.htrans, bus.hwrite, bus.hsize, bus.hprot, bus.haddr);
        end
        next_cyc();
        bus.hready_data = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.hwdata, bus.HSEL2, bus.htrans, bus.dm_rvalid} !== {32'hDEAD_BEEF, 1'b1, 2'b00, 1'b0}) begin
                errors++; $display("FAIL st_stall%0d got %h %b %b %b", i, bus.hwdata, bus.HSEL2, bus.htrans, bus.dm_rvalid);
            end
            if (i == 0) next_cyc();
        end
        next_cyc();
        bus.hready_data = 1;
        wait_rsp(cyc);
        checks++;
        if (cyc != 2) begin errors++; $display("FAIL st_lat got %0d want 2", cyc); end
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL st_rsp got %h want none", obs()); end
        else begin
            e = sb.pop_front();
            if (obs() !== e) begin errors++; $display("FAIL st_rsp got %h want %h", obs(), e); end
        end
        next_cyc();
    endtask

    task automatic test_dec_err();
        logic [31:0] da [5];
        logic [2:0]  ds [5];
        logic        dw [5];
        int cyc;
        logic [34:0] e;
        da = '{32'h0000_0000, 32'h1000_0003, 32'h2000_0000, 32'h1000_0000, 32'h1000_0002};
        ds = '{3'd2, 3'd1, 3'd2, 3'd3, 3'd2};
        dw = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        bus.load_out = 32'h5555_AAAA;
        for (int k = 0; k < 5; k++) begin
            bus.dm_req = 1; bus.dm_addr = da[k]; bus.dm_size = ds[k]; bus.dm_we = dw[k];
            @(negedge clk);
            checks++;
            if ({bus.dm_gnt, bus.HSEL1, bus.HSEL2, bus.htrans} !== 5'b10000) begin
                errors++; $display("FAIL dec%0d_gnt got %b%b%b %b", k, bus.dm_gnt, bus.HSEL1, bus.HSEL2, bus.htrans);
            end
            sb.push_back({2'b01, 1'b1, 32'h0});
            next_cyc();
            bus.dm_req = 0; bus.dm_we = 0;
            wait_rsp(cyc);
            checks++;
            if ({cyc == 1, bus.HSEL1, bus.HSEL2, bus.htrans} !== 5'b10000) begin
                errors++; $display("FAIL dec%0d_bus got lat %0d sel %b%b htrans %b", k, cyc, bus.HSEL1, bus.HSEL2, bus.htrans);
            end
            checks++;
            if (sb.size() == 0) begin errors++; $display("FAIL dec%0d_rsp got %h want none", k, obs()); end
            else begin
                e = sb.pop_front();
                if (obs() !== e) begin errors++; $display("FAIL dec%0d_rsp got %h want %h", k, obs(), e); end
            end
            next_cyc();
        end
        bus.dm_size = HSIZE_WORD;
    endtask

    task automatic test_signed_err();
        int cyc;
        logic [34:0] e;
        // Byte signed load answered with an error response.
        bus.load_out = 32'h0000_0080; bus.hresp_data = 1;
        bus.dm_req = 1; bus.dm_addr = 32'h1000_0000; bus.dm_size = HSIZE_BYTE; bus.dm_signed = 1;
        @(negedge clk);
        sb.push_back({2'b01, 1'b1, 32'h0000_0080});
        next_cyc();
        bus.dm_req = 0; bus.dm_signed = 0;
        @(negedge clk);
        checks++;
        if ({bus.is_signed, bus.hsize, bus.hprot, bus.htrans, bus.HSEL2} !== {1'b1, 3'd0, 4'b0011, 2'b10, 1'b1}) begin
            errors++; $display("FAIL sg_addr got %b %0d %b %b %b", bus.is_signed, bus.hsize, bus.hprot, bus.htrans, bus.HSEL2);
        end
        wait_rsp(cyc);
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL sg_rsp got %h want none", obs()); end
        else begin
            e = sb.pop_front();
            if (obs() !== e || cyc != 2) begin errors++; $display("FAIL sg_rsp got %h lat %0d want %h lat 2", obs(), cyc, e); end
        end
        next_cyc();
        // hresp high only while stalled must not be reported.
        bus.hresp_data = 0; bus.load_out = 32'h7654_3210;
        bus.dm_req = 1; bus.dm_addr = 32'h1000_000C; bus.dm_size = HSIZE_WORD;
        @(negedge clk);
        sb.push_back({2'b01, 1'b0, 32'h7654_3210});
        next_cyc();
        bus.dm_req = 0;
        next_cyc();
        bus.hready_data = 0; bus.hresp_data = 1;
        next_cyc();
        bus.hready_data = 1; bus.hresp_data = 0;
        wait_rsp(cyc);
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL sg_stall_rsp got %h want none", obs()); end
        else begin
            e = sb.pop_front();
            if (obs() !== e || cyc != 2) begin errors++; $display("FAIL sg_stall_rsp got %h lat %0d want %h lat 2", obs(), cyc, e); end
        end
        next_cyc();
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        bus.instruction = 32'hCAFE_F00D;
        bus.if_req = 1; bus.if_addr = 32'h0000_0040;
        @(negedge clk);
        next_cyc();
        bus.if_req = 0;
        next_cyc();
        bus.hready_inst = 0;
        @(negedge clk);
        checks++;
        if ({bus.HSEL1, bus.htrans} !== 3'b100) begin errors++; $display("FAIL rm_data got %b %b want 1 00", bus.HSEL1, bus.htrans); end
        #1 reset = 0;
        #1;
        checks++;
        if ({bus.HSEL1, bus.htrans, bus.if_rvalid, bus.haddr, bus.hprot, bus.hsize} !== '0) begin
            errors++; $display("FAIL rm_async got sel %b htrans %b rv %b addr %h", bus.HSEL1, bus.htrans, bus.if_rvalid, bus.haddr);
        end
        next_cyc();
        bus.hready_inst = 1;
        next_cyc();
        reset = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.if_rvalid || bus.dm_rvalid) pulses++;
        end
        checks++;
        if (pulses != 0 || bus.htrans !== 2'b00) begin errors++; $display("FAIL rm_drop got %0d pulses htrans %b want 0 00", pulses, bus.htrans); end
    endtask

    initial begin
        test_reset();
        test_arb();
        test_fetch();
        test_store_stall();
        test_dec_err();
        test_signed_err();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL sb_left got %0d want 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
